uart_alu_ctrl: RTL and testbench
================================

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed between bytes within one packet before the packet is aborted.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port s_axis_tdata, input, 8: received byte from the UART receiver.
REQ-005 SHALL have port s_axis_tvalid, input, 1: received byte valid.
REQ-006 SHALL have port s_axis_tready, output, 1: controller accepts the received byte.
REQ-007 SHALL have port m_axis_tdata, output, 8: byte to the UART transmitter.
REQ-008 SHALL have port m_axis_tvalid, output, 1: transmit byte valid.
REQ-009 SHALL have port m_axis_tready, input, 1: transmitter accepts the byte.
REQ-010 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port err_count, output, 8: count of timeouts plus error responses; saturates at 0xFF.

Function
REQ-012 SHALL use this packet format: byte0 = opcode; byte1 = N, the operand count; then N 32-bit operands, each little-endian.
REQ-013 SHALL support these opcodes:
- 0x00 ECHO: retransmit the operand bytes unchanged.
- 0x01 ADD: 32-bit sum, mod 2^32.
- 0x02 MUL: low 32 bits of the unsigned product.
- 0x03 XOR: bitwise XOR of all operands.
REQ-014 SHALL use the states IDLE, GET_N, GET_OPND, SEND_RES, SEND_ERR.
REQ-015 SHALL define a byte transfer as occurring only on a cycle where tvalid and tready are both high on the same interface.
REQ-016 SHALL, in IDLE, drive s_axis_tready=1; on a byte transfer it latches the opcode and goes to GET_N.
REQ-017 SHALL, in GET_N, latch N on a byte transfer.
- N=0: go to SEND_ERR with error byte 0xFE.
- Otherwise: go to GET_OPND with the accumulator set to the opcode identity (ADD/XOR 0, MUL 1).
REQ-018 SHALL, in GET_OPND, assemble each operand from 4 bytes, LSB first.
- The combine step for ADD, MUL or XOR executes in the cycle the 4th byte transfers.
- After the last byte of the Nth operand: go to SEND_RES (ADD/MUL/XOR), to IDLE (ECHO), or to SEND_ERR with 0xFF (unknown opcode).
- For an unknown opcode, all 4N operand bytes are consumed and discarded before the error is sent.
REQ-019 SHALL, for ECHO, pass each operand byte through a one-entry output register.
- s_axis_tready = !m_axis_tvalid.
- The byte appears on m_axis_tdata the cycle after its receive transfer.
REQ-020 SHALL, in SEND_RES, emit the 4 result bytes LSB first, then return to IDLE; s_axis_tready=0 throughout.
REQ-021 SHALL, in SEND_ERR, emit the single error byte, increment err_count, then return to IDLE.
REQ-022 SHALL hold m_axis_tdata and m_axis_tvalid stable until m_axis_tready=1; m_axis_tvalid never drops before the byte is accepted.
REQ-023 SHALL apply the timeout in GET_N and GET_OPND.
- A counter resets on every receive transfer.
- When the counter reaches TIMEOUT_CYCLES: return to IDLE, discard the partial packet, increment err_count, send no output.
- In ECHO, an already-registered output byte is still delivered.
REQ-024 SHALL never emit a result byte before the final operand byte has transferred (minimum latency: first result byte valid 1 cycle after it).
REQ-025 SHALL NOT let err_count wrap: an increment at 0xFF leaves 0xFF.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, force the following:
- state IDLE;
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0x00;
- busy=0, err_count=0x00;
- accumulator and timeout counter cleared.
REQ-027 SHALL, on reset asserted mid-packet or mid-transmit, abandon the packet; no further bytes of it are emitted after rst returns high.
REQ-028 SHALL drive s_axis_tready=1 on the first cycle after rst is deasserted.

Verification
REQ-029 SHALL cover ADD: rx 01 02 05 00 00 00 03 00 00 00 -> tx 08 00 00 00; err_count=0.
REQ-030 SHALL cover MUL overflow: rx 02 02 00 00 01 00 00 00 01 00 -> tx 00 00 00 00.
REQ-031 SHALL cover ECHO with backpressure: rx 00 01 AA BB CC DD, with m_axis_tready low for 10 cycles after the first byte -> tx AA BB CC DD, data held stable while stalled.
REQ-032 SHALL cover the error paths:
- rx 7F 01 11 22 33 44 -> tx FF, err_count=1.
- rx 03 00 -> tx FE, err_count=2.
REQ-033 SHALL cover timeout: rx 01 02 05, then idle TIMEOUT_CYCLES+5 cycles -> no tx, err_count=1, busy=0; a following ADD packet produces a correct result.
REQ-034 SHALL cover reset during SEND_RES after 2 result bytes -> no further tx, all outputs at reset values, next packet processed correctly.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: byte-stream packet controller between a UART receiver and
// transmitter. Decodes opcode/count/operand packets, runs ECHO/ADD/MUL/XOR,
// and streams back results or a one-byte error code. An idle timeout
// aborts stalled packets, and err_count tallies timeouts and error replies.
module uart_alu_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_ECHO = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;

    localparam logic [7:0] ERR_ZERO_N = 8'hFE;
    localparam logic [7:0] ERR_BAD_OP = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        GET_N,
        GET_OPND,
        SEND_RES,
        SEND_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    opnd_left_q, opnd_left_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   acc_q, acc_d;
    logic [2:0]    res_idx_q, res_idx_d;
    logic [7:0]    err_byte_q, err_byte_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_ready;
    logic          rx_fire;
    logic          tx_free;
    logic          tmo_hit;
    logic [31:0]   operand;
    logic [31:0]   result;

    // Starting accumulator value for each arithmetic opcode.
    function automatic logic [31:0] alu_identity(input logic [7:0] op);
        return (op == OP_MUL) ? 32'd1 : 32'd0;
    endfunction

    // One accumulate step; unknown opcodes leave the accumulator untouched.
    function automatic logic [31:0] alu_combine(input logic [7:0]  op,
                                                input logic [31:0] acc,
                                                input logic [31:0] opnd);
        case (op)
            OP_ADD:  return acc + opnd;
            OP_MUL:  return acc * opnd;
            OP_XOR:  return acc ^ opnd;
            default: return acc;
        endcase
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The fourth operand byte arrives live on the bus; the first three are held.
    assign operand = {s_axis_tdata, shift_q};
    assign result  = alu_combine(opcode_q, acc_q, operand);

    // Receive readiness per state; ECHO only accepts when the output slot is empty.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            IDLE, GET_N: rx_ready = 1'b1;
            GET_OPND:    rx_ready = (opcode_q == OP_ECHO) ? !tx_valid_q : 1'b1;
            default:     rx_ready = 1'b0;
        endcase
    end

    assign s_axis_tready = rst & rx_ready;
    assign rx_fire       = s_axis_tvalid & s_axis_tready;
    assign tx_free       = !tx_valid_q | m_axis_tready;
    assign tmo_hit       = (tmo_q == TMO_LAST);

    assign m_axis_tdata  = tx_data_q;
    assign m_axis_tvalid = tx_valid_q;
    assign busy          = (state_q != IDLE);
    assign err_count     = err_cnt_q;

    // Next-state and datapath updates for the packet FSM.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        opnd_left_d = opnd_left_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        res_idx_d   = res_idx_q;
        err_byte_d  = err_byte_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q & !m_axis_tready;
        err_cnt_d   = err_cnt_q;
        tmo_d       = '0;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    opcode_d = s_axis_tdata;
                    state_d  = GET_N;
                end
            end

            GET_N: begin
                if (rx_fire) begin
                    if (s_axis_tdata == 8'd0) begin
                        err_byte_d = ERR_ZERO_N;
                        res_idx_d  = 3'd0;
                        state_d    = SEND_ERR;
                    end else begin
                        opnd_left_d = s_axis_tdata;
                        byte_idx_d  = 2'd0;
                        acc_d       = alu_identity(opcode_q);
                        state_d     = GET_OPND;
                    end
                end else if (tmo_hit) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            GET_OPND: begin
                if (rx_fire) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    shift_d    = {s_axis_tdata, shift_q[23:8]};
                    if (opcode_q == OP_ECHO) begin
                        tx_data_d  = s_axis_tdata;
                        tx_valid_d = 1'b1;
                    end
                    if (byte_idx_q == 2'd3) begin
                        acc_d       = result;
                        opnd_left_d = opnd_left_q - 8'd1;
                        if (opnd_left_q == 8'd1) begin
                            case (opcode_q)
                                OP_ECHO: state_d = IDLE;
                                OP_ADD, OP_MUL, OP_XOR: begin
                                    state_d = SEND_RES;
                                    // Launch the low byte right away when the slot is free.
                                    if (tx_free) begin
                                        tx_data_d  = result[7:0];
                                        tx_valid_d = 1'b1;
                                        res_idx_d  = 3'd1;
                                    end else begin
                                        res_idx_d  = 3'd0;
                                    end
                                end
                                default: begin
                                    err_byte_d = ERR_BAD_OP;
                                    res_idx_d  = 3'd0;
                                    state_d    = SEND_ERR;
                                end
                            endcase
                        end
                    end
                end else if (tmo_hit) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            SEND_RES: begin
                // Stay until the fourth byte has been accepted.
                if (tx_free) begin
                    if (res_idx_q != 3'd4) begin
                        tx_data_d  = 8'(acc_q >> {res_idx_q[1:0], 3'b000});
                        tx_valid_d = 1'b1;
                        res_idx_d  = res_idx_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            SEND_ERR: begin
                if (tx_free) begin
                    if (res_idx_q == 3'd0) begin
                        tx_data_d  = err_byte_q;
                        tx_valid_d = 1'b1;
                        res_idx_d  = 3'd1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, output slot, counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            opcode_q    <= 8'd0;
            opnd_left_q <= 8'd0;
            byte_idx_q  <= 2'd0;
            shift_q     <= 24'd0;
            acc_q       <= 32'd0;
            res_idx_q   <= 3'd0;
            err_byte_q  <= 8'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
            tmo_q       <= '0;
        end else begin
            opcode_q    <= opcode_d;
            opnd_left_q <= opnd_left_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            res_idx_q   <= res_idx_d;
            err_byte_q  <= err_byte_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            err_cnt_q   <= err_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: directed packets from the requirement list plus
// randomized packets checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_uart_alu_ctrl;

    localparam int TMO = 40;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy;
    logic [7:0] err_count;

    bit   bp_rand = 1'b0;
    logic tready_man = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int exp_err = 0;

    bq_t got_q;

    uart_alu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Transmit-side ready: random backpressure or a manually set level.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_axis_tready = bp_rand ? ($urandom_range(0, 3) != 0) : tready_man;
        end
    end

    // Record every byte the transmitter accepts.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packet-level reference: what the transmitter should see and how many errors count.
    function automatic bq_t model(input bq_t pkt, output int errinc);
        bq_t               r;
        longint unsigned   acc;
        logic [31:0]       opnd;
        int                n;
        r = {};
        errinc = 0;
        n = int'(pkt[1]);
        if (n == 0) begin
            r.push_back(8'hFE);
            errinc = 1;
            return r;
        end
        acc = (pkt[0] == 8'h02) ? 64'd1 : 64'd0;
        for (int i = 0; i < n; i++) begin
            opnd = {pkt[2+4*i+3], pkt[2+4*i+2], pkt[2+4*i+1], pkt[2+4*i]};
            case (pkt[0])
                8'h01:   acc = (acc + opnd) % 64'h1_0000_0000;
                8'h02:   acc = (acc * opnd) % 64'h1_0000_0000;
                8'h03:   acc = acc ^ opnd;
                default: acc = acc;
            endcase
        end
        if (pkt[0] == 8'h00) begin
            for (int i = 2; i < pkt.size(); i++) r.push_back(pkt[i]);
        end else if (pkt[0] <= 8'h03) begin
            for (int k = 0; k < 4; k++) r.push_back(8'(acc >> (8 * k)));
        end else begin
            r.push_back(8'hFF);
            errinc = 1;
        end
        return r;
    endfunction

    function automatic string fmt(input bq_t q);
        string s;
        s = "";
        for (int i = 0; i < q.size() && i < 32; i++) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic bit same(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bq_t collect(input int base);
        bq_t r;
        r = {};
        for (int i = base; i < got_q.size(); i++) r.push_back(got_q[i]);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_accept: byte %02h not accepted within 500 cycles", b);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t pkt, input int max_gap);
        foreach (pkt[i]) begin
            send_byte(pkt[i]);
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || m_axis_tvalid) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (busy || m_axis_tvalid) begin
            miscompares++;
            $display("FAIL %s_done: busy=%0b tvalid=%0b after %0d cycles, want both 0", name, busy, m_axis_tvalid, n);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); end
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata !== 8'h00) begin miscompares++; $display("FAIL rst_m_tdata: got %h want 00", m_axis_tdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL rst_err: got %h want 00", err_count); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err = 0;
        @(negedge clk);
        vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL post_rst_tready: got %b want 1", s_axis_tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        bq_t pkt, exp, got;
        int  base;
        pkt = {8'h01, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        exp = {8'h08, 8'h00, 8'h00, 8'h00};
        base = got_q.size();
        for (int i = 0; i < pkt.size() - 1; i++) send_byte(pkt[i]);
        repeat (2) @(negedge clk);
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL add_early: tvalid %b before last byte, want 0", m_axis_tvalid); end
        @(posedge clk);
        #1;
        send_byte(pkt[pkt.size()-1]);
        wait_done("add");
        got = collect(base);
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL add_tx: got %s want %s", fmt(got), fmt(exp)); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL add_err: got %0d want 0", err_count); end
    endtask

    task automatic test_mul_overflow;
        bq_t pkt, exp, got;
        int  base;
        pkt = {8'h02, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        exp = {8'h00, 8'h00, 8'h00, 8'h00};
        base = got_q.size();
        send_pkt(pkt, 2);
        wait_done("mul");
        got = collect(base);
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL mul_tx: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_echo_backpressure;
        bq_t pkt, exp, got;
        int  base;
        bit  stable;
        pkt = {8'h00, 8'h01, 8'hAA};
        exp = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        tready_man = 1'b0;
        @(posedge clk);
        #1;
        base = got_q.size();
        send_pkt(pkt, 0);
        stable = 1'b1;
        fork
            begin
                send_byte(8'hBB);
                send_byte(8'hCC);
                send_byte(8'hDD);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 8'hAA && s_axis_tready === 1'b0)) stable = 1'b0;
                end
                tready_man = 1'b1;
            end
        join
        vectors++; if (!stable) begin miscompares++; $display("FAIL echo_hold: output not held at AA during stall (now tvalid=%b data=%h)", m_axis_tvalid, m_axis_tdata); end
        wait_done("echo");
        got = collect(base);
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL echo_tx: got %s want %s", fmt(got), fmt(exp)); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL echo_err: got %0d want 0", err_count); end
    endtask

    task automatic test_errors;
        bq_t got, exp;
        int  base;
        base = got_q.size();
        send_pkt({8'h7F, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1);
        wait_done("badop");
        got = collect(base);
        exp = {8'hFF};
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL badop_tx: got %s want %s", fmt(got), fmt(exp)); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL badop_err: got %0d want 1", err_count); end
        base = got_q.size();
        send_pkt({8'h03, 8'h00}, 1);
        wait_done("zeron");
        got = collect(base);
        exp = {8'hFE};
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL zeron_tx: got %s want %s", fmt(got), fmt(exp)); end
        vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL zeron_err: got %0d want 2", err_count); end
    endtask

    task automatic test_timeout;
        bq_t got, exp;
        int  base;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err = 0;
        base = got_q.size();
        send_pkt({8'h01, 8'h02, 8'h05}, 0);
        repeat (TMO + 5) @(posedge clk);
        @(negedge clk);
        vectors++; if (got_q.size() != base) begin miscompares++; $display("FAIL tmo_tx: got %0d bytes want 0", got_q.size() - base); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL tmo_err: got %0d want 1", err_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        base = got_q.size();
        send_pkt({8'h01, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40}, 1);
        wait_done("tmo_add");
        got = collect(base);
        exp = {8'h10, 8'h20, 8'h30, 8'h40};
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL tmo_add_tx: got %s want %s", fmt(got), fmt(exp)); end
        exp_err = 1;
    endtask

    task automatic test_random;
        bq_t pkt, exp, got;
        int  base, inc, n;
        logic [7:0] op;
        for (int p = 0; p < 40; p++) begin
            bp_rand = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
                0: op = 8'h00;
                1: op = 8'h01;
                2: op = 8'h02;
                3: op = 8'h03;
                4: op = 8'h03;
                default: op = 8'($urandom_range(4, 255));
            endcase
            n = $urandom_range(0, 4);
            pkt = {op, 8'(n)};
            for (int i = 0; i < 4 * n; i++) pkt.push_back(8'($urandom_range(0, 255)));
            exp = model(pkt, inc);
            exp_err = (exp_err + inc > 255) ? 255 : exp_err + inc;
            base = got_q.size();
            send_pkt(pkt, 3);
            wait_done("rand");
            got = collect(base);
            vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL rand_tx[%0d] op=%02h n=%0d: got %s want %s", p, op, n, fmt(got), fmt(exp)); end
            vectors++; if (err_count !== 8'(exp_err)) begin miscompares++; $display("FAIL rand_err[%0d]: got %0d want %0d", p, err_count, exp_err); end
        end
        bp_rand = 1'b0;
        tready_man = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midsend;
        bq_t got, exp;
        int  base, n;
        tready_man = 1'b0;
        @(posedge clk);
        #1;
        base = got_q.size();
        send_pkt({8'h01, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
        n = 0;
        @(negedge clk);
        while (!m_axis_tvalid && n < 100) begin n++; @(negedge clk); end
        @(posedge clk);
        #1;
        tready_man = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tready_man = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1 while result bytes remain", busy); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if ({s_axis_tready, m_axis_tvalid, busy} !== 3'b000) begin miscompares++; $display("FAIL mid_rst_ctrl: got tready/tvalid/busy=%b want 000", {s_axis_tready, m_axis_tvalid, busy}); end
        vectors++; if ({m_axis_tdata, err_count} !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_data: got tdata=%h err=%h want 00 00", m_axis_tdata, err_count); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err = 0;
        tready_man = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        got = collect(base);
        exp = {8'h78, 8'h56};
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL mid_tx: got %s want %s", fmt(got), fmt(exp)); end
        base = got_q.size();
        send_pkt({8'h02, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00}, 1);
        wait_done("mid_next");
        got = collect(base);
        exp = {8'h0F, 8'h00, 8'h00, 8'h00};
        vectors++; if (!same(got, exp)) begin miscompares++; $display("FAIL mid_next_tx: got %s want %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_err_saturate;
        int  base, bad;
        bq_t got;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 260; i++) begin
            send_pkt({8'h01, 8'h00}, 0);
            wait_done("sat");
            if (i == 254) begin
                vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_reach: got %h want ff after 255 errors", err_count); end
            end
        end
        vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("FAIL sat_hold: got %h want ff after 260 errors", err_count); end
        got = collect(base);
        bad = 0;
        foreach (got[i]) if (got[i] !== 8'hFE) bad++;
        vectors++; if (got.size() != 260 || bad != 0) begin miscompares++; $display("FAIL sat_tx: got %0d bytes (%0d not FE) want 260 FE", got.size(), bad); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_overflow();
        test_echo_backpressure();
        test_errors();
        test_timeout();
        test_random();
        test_reset_midsend();
        test_err_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
